inst_fetcher: RTL and testbench

Front-end instruction fetcher. It owns the PC, requests instruction words from the icache, and presents each raw word to the Decoder (_inst_in/_inst_ready_in/_inst_addr/_clear). It consumes the Decoder's _next_pc, _stall, _formalized_inst and _rvc, and pushes decoded instructions into the instruction queue. It handles jalr stalls and ROB redirects/flushes.

---
 rtl/inst_fetcher.sv | 159 +++++++++++++++
 tb/tb_inst_fetcher.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetcher.sv
// inst_fetcher: owns the PC, fetches one instruction word at a time from the icache,
// hands the raw word to the decoder and pushes the decoded instruction into the IQ.
// Latency: icache latency + 2 cycles from fetch start to push. Backpressure: _iq_full
// holds the word in DECODE, rdy_in low freezes every register, _br_rob flushes/redirects.
//
// Ports:
//   clk_in, rst_in, rdy_in          clock, sync active-high reset, global enable
//   _br_rob                         ROB redirect; _next_pc then carries the ROB target
//   _next_pc/_stall/_formalized_inst/_rvc   decoder results for the current word
//   _icache_req/_icache_addr        level-held fetch request and halfword address
//   _icache_ready/_icache_data      one-cycle response pulse and 32 bits at the address
//   _inst_out/_inst_ready_out/_inst_addr_out/_clear_out   raw word interface to decoder
//   _iq_full/_iq_push/_iq_inst/_iq_pc/_iq_rvc             instruction queue push side
module inst_fetcher #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _br_rob,
    input  logic [31:0] _next_pc,
    input  logic        _stall,
    input  logic [31:0] _formalized_inst,
    input  logic        _rvc,
    output logic        _icache_req,
    output logic [31:0] _icache_addr,
    input  logic        _icache_ready,
    input  logic [31:0] _icache_data,
    output logic [31:0] _inst_out,
    output logic        _inst_ready_out,
    output logic [31:0] _inst_addr_out,
    output logic        _clear_out,
    input  logic        _iq_full,
    output logic        _iq_push,
    output logic [31:0] _iq_inst,
    output logic [31:0] _iq_pc,
    output logic        _iq_rvc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DECODE,
        S_STALL,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_addr_q, inst_addr_d;
    logic        inst_rdy_q, inst_rdy_d;
    logic        clear_q, clear_d;
    logic        push_c;
    logic [31:0] target_pc;

    // Instructions are halfword aligned, so bit 0 of any target is dropped.
    assign target_pc = _next_pc & ~32'h1;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        inst_addr_d = inst_addr_q;
        inst_rdy_d  = inst_rdy_q;
        clear_d     = 1'b0;
        push_c      = 1'b0;

        if (_br_rob) begin
            pc_d       = target_pc;
            inst_rdy_d = 1'b0;
            case (state_q)
                // A request is still outstanding unless its data lands this cycle;
                // DRAIN swallows the stale response before a new fetch starts.
                S_WAIT: begin
                    clear_d = 1'b1;
                    state_d = _icache_ready ? S_IDLE : S_DRAIN;
                end
                // Already flushing: only retarget, the drain still has to finish.
                S_DRAIN: begin
                    if (_icache_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    clear_d = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (_icache_ready) begin
                        inst_d      = _icache_data;
                        inst_addr_d = pc_q;
                        inst_rdy_d  = 1'b1;
                        state_d     = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!_iq_full) begin
                        push_c = 1'b1;
                        if (_stall) begin
                            // jalr: its target is unknown until the ROB resolves it.
                            state_d = S_STALL;
                        end else begin
                            pc_d       = target_pc;
                            inst_rdy_d = 1'b0;
                            state_d    = S_IDLE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (_icache_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC & ~32'h1;
            inst_q      <= 32'h0;
            inst_addr_q <= RESET_PC & ~32'h1;
            inst_rdy_q  <= 1'b0;
            clear_q     <= 1'b0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            inst_addr_q <= inst_addr_d;
            inst_rdy_q  <= inst_rdy_d;
            clear_q     <= clear_d;
        end
    end

    // Request and address come straight from registered state, so they hold
    // their values whenever rdy_in freezes the registers.
    assign _icache_req    = (state_q == S_WAIT);
    assign _icache_addr   = pc_q & ~32'h1;
    assign _inst_out      = inst_q;
    assign _inst_ready_out = inst_rdy_q;
    assign _inst_addr_out = inst_addr_q;
    assign _clear_out     = clear_q;
    assign _iq_push       = push_c && rdy_in && !rst_in;
    assign _iq_inst       = _formalized_inst;
    assign _iq_pc         = inst_addr_q;
    assign _iq_rvc        = _rvc;

endmodule

// File: tb/tb_inst_fetcher.sv
// tb_inst_fetcher: drives inst_fetcher with a behavioural icache and decoder stub and
// checks the pushed instruction stream against a program-walk reference model.
// Latency: n/a (bench). Backpressure: bench toggles _iq_full, rdy_in and _br_rob.
module tb_inst_fetcher;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        br_rob = 1'b0;
    logic [31:0] rob_target = 32'h0;
    logic        iq_full = 1'b0;
    logic        icache_ready = 1'b0;
    logic [31:0] icache_data = 32'h0;
    logic        icache_req, inst_ready, clear_out, iq_push, iq_rvc, stall, rvc;
    logic [31:0] icache_addr, inst_out, inst_addr, iq_inst, iq_pc, next_pc, form_inst;

    localparam logic [31:0] JALR = 32'h00008067;
    localparam logic [15:0] CLI  = 16'h4085;

    always #5 clk = ~clk;

    logic [15:0] mem [0:2047];

    function automatic logic [31:0] fetch(input logic [31:0] a);
        logic [10:0] i0, i1;
        i0 = a[11:1];
        i1 = i0 + 11'd1;
        return {mem[i1], mem[i0]};
    endfunction

    function automatic logic is_rvc(input logic [31:0] w);
        return w[1:0] != 2'b11;
    endfunction

    function automatic logic is_jalr(input logic [31:0] w);
        return !is_rvc(w) && w[6:0] == 7'b1100111;
    endfunction

    function automatic logic [31:0] step_pc(input logic [31:0] w, input logic [31:0] pc);
        if (is_rvc(w)) return pc + 32'd2;
        if (w[6:0] == 7'b1101111)
            return pc + {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] formal(input logic [31:0] w);
        return is_rvc(w) ? {16'hE000, w[15:0]} : w;
    endfunction

    function automatic logic [31:0] enc_jal(input logic [20:0] off);
        return {off[20], off[10:1], off[11], off[19:12], 5'd0, 7'b1101111};
    endfunction

    // Decoder stub: a tiny RV32C-aware decoder of the raw word.
    assign next_pc   = br_rob ? rob_target : step_pc(inst_out, inst_addr);
    assign stall     = inst_ready && is_jalr(inst_out);
    assign form_inst = formal(inst_out);
    assign rvc       = is_rvc(inst_out);

    inst_fetcher #(.RESET_PC(32'h0)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), ._br_rob(br_rob), ._next_pc(next_pc),
        ._stall(stall), ._formalized_inst(form_inst), ._rvc(rvc),
        ._icache_req(icache_req), ._icache_addr(icache_addr),
        ._icache_ready(icache_ready), ._icache_data(icache_data),
        ._inst_out(inst_out), ._inst_ready_out(inst_ready), ._inst_addr_out(inst_addr),
        ._clear_out(clear_out), ._iq_full(iq_full), ._iq_push(iq_push),
        ._iq_inst(iq_inst), ._iq_pc(iq_pc), ._iq_rvc(iq_rvc)
    );

    // Icache: accepts a request, answers with a one-cycle pulse lat cycles later.
    int          lat = 1;
    logic        busy = 1'b0;
    int          cnt = 0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] reqs [$];

    always @(negedge clk) begin
        if (rst) begin
            busy = 1'b0;
            icache_ready = 1'b0;
        end else if (icache_ready) begin
            icache_ready = 1'b0;
            busy = 1'b0;
        end else if (busy) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                icache_ready = 1'b1;
                icache_data = fetch(req_addr);
            end
        end else if (icache_req && rdy) begin
            busy = 1'b1;
            cnt = lat;
            req_addr = icache_addr;
            reqs.push_back(icache_addr);
        end
    end

    // Monitor: records pushes and clear pulses a little before each active edge.
    int          cyc = 0;
    int          clears = 0;
    logic [31:0] got_pc [$];
    logic [31:0] got_inst [$];
    logic        got_rvc [$];
    int          got_cyc [$];

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        #3;
        if (iq_push) begin
            got_pc.push_back(iq_pc);
            got_inst.push_back(iq_inst);
            got_rvc.push_back(iq_rvc);
            got_cyc.push_back(cyc);
        end
        if (clear_out) clears = clears + 1;
    end

    // Reference model: walk the program as the fetcher must, one push per instruction.
    logic [31:0] exp_pc [$];
    logic [31:0] exp_inst [$];
    logic        exp_rvc [$];
    logic [31:0] exp_req [$];

    task automatic model_walk(input logic [31:0] start);
        logic [31:0] pc, w;
        pc = start;
        for (int k = 0; k < 64; k++) begin
            w = fetch(pc);
            exp_pc.push_back(pc);
            exp_req.push_back(pc);
            exp_inst.push_back(formal(w));
            exp_rvc.push_back(is_rvc(w));
            if (is_jalr(w)) break;
            pc = step_pc(w, pc);
        end
    endtask

    int checks = 0;
    int passes = 0;
    int rel = 0;

    task automatic put32(input logic [31:0] a, input logic [31:0] w);
        mem[a[11:1]] = w[15:0];
        mem[a[11:1] + 11'd1] = w[31:16];
    endtask

    task automatic put16(input logic [31:0] a, input logic [15:0] h);
        mem[a[11:1]] = h;
    endtask

    function automatic logic [31:0] rand_addi();
        logic [31:0] r;
        r = $urandom();
        return {r[31:7], 7'b0010011};
    endfunction

    task automatic mem_clear();
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
        exp_pc.delete(); exp_inst.delete(); exp_rvc.delete(); exp_req.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; rdy = 1'b1; br_rob = 1'b0;
        repeat (2) @(negedge clk);
        got_pc.delete(); got_inst.delete(); got_rvc.delete(); got_cyc.delete();
        reqs.delete();
        clears = 0;
        rst = 1'b0;
        rel = cyc;
    endtask

    task automatic wait_pushes(input int n, input int budget);
        int b;
        b = budget;
        while (got_pc.size() < n && b > 0) begin
            @(negedge clk);
            b--;
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; rdy = 1'b0; iq_full = 1'b0; br_rob = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (icache_req !== 1'b0) $display("FAIL reset_req: got %b want 0", icache_req); else passes++;
        checks++; if (icache_addr !== 32'h0) $display("FAIL reset_pc: got %h want 0", icache_addr); else passes++;
        checks++; if (inst_ready !== 1'b0) $display("FAIL reset_inst_ready: got %b want 0", inst_ready); else passes++;
        checks++; if (inst_out !== 32'h0) $display("FAIL reset_inst: got %h want 0", inst_out); else passes++;
        checks++; if (clear_out !== 1'b0) $display("FAIL reset_clear: got %b want 0", clear_out); else passes++;
        checks++; if (iq_push !== 1'b0) $display("FAIL reset_push: got %b want 0", iq_push); else passes++;
        rdy = 1'b1;
    endtask

    // Shared stream comparison body is written out per test on purpose (tag names differ).
    task automatic test_sequential();
        mem_clear();
        for (int i = 0; i < 4; i++) put32(32'(i * 4), rand_addi());
        put32(32'h10, JALR);
        model_walk(32'h0);
        lat = 1;
        do_reset();
        wait_pushes(exp_pc.size(), 200);
        checks++; if (got_pc.size() != exp_pc.size()) $display("FAIL seq_count: got %0d want %0d", got_pc.size(), exp_pc.size()); else passes++;
        for (int i = 0; i < exp_pc.size(); i++) begin
            checks++;
            if (i >= got_pc.size() || got_pc[i] !== exp_pc[i] || got_inst[i] !== exp_inst[i] || got_rvc[i] !== exp_rvc[i])
                $display("FAIL seq_push%0d: got pc %h inst %h want pc %h inst %h", i, got_pc[i], got_inst[i], exp_pc[i], exp_inst[i]);
            else passes++;
            checks++; if (reqs[i] !== exp_req[i]) $display("FAIL seq_addr%0d: got %h want %h", i, reqs[i], exp_req[i]); else passes++;
        end
        checks++; if (got_cyc[0] - rel != 3) $display("FAIL seq_latency: got %0d want 3", got_cyc[0] - rel); else passes++;
        for (int i = 1; i < got_cyc.size(); i++) begin
            checks++; if (got_cyc[i] - got_cyc[i-1] != 4) $display("FAIL seq_interval%0d: got %0d want 4", i, got_cyc[i] - got_cyc[i-1]); else passes++;
        end
    endtask

    task automatic test_rvc();
        mem_clear();
        put16(32'h0, CLI);
        put32(32'h2, rand_addi());
        put32(32'h6, JALR);
        model_walk(32'h0);
        lat = 2;
        do_reset();
        wait_pushes(exp_pc.size(), 200);
        checks++; if (got_pc.size() != 3) $display("FAIL rvc_count: got %0d want 3", got_pc.size()); else passes++;
        for (int i = 0; i < exp_pc.size(); i++) begin
            checks++;
            if (i >= got_pc.size() || got_pc[i] !== exp_pc[i] || got_inst[i] !== exp_inst[i] || got_rvc[i] !== exp_rvc[i])
                $display("FAIL rvc_push%0d: got pc %h rvc %b want pc %h rvc %b", i, got_pc[i], got_rvc[i], exp_pc[i], exp_rvc[i]);
            else passes++;
        end
        checks++; if (reqs[1] !== 32'h2) $display("FAIL rvc_addr: got %h want 00000002", reqs[1]); else passes++;
    endtask

    task automatic test_jal();
        mem_clear();
        for (int i = 0; i < 4; i++) put32(32'(i * 4), rand_addi());
        put32(32'h10, enc_jal(21'h100));
        put32(32'h110, JALR);
        model_walk(32'h0);
        lat = 1;
        do_reset();
        wait_pushes(exp_pc.size(), 300);
        checks++; if (reqs.size() != exp_req.size()) $display("FAIL jal_reqs: got %0d want %0d", reqs.size(), exp_req.size()); else passes++;
        for (int i = 0; i < exp_pc.size(); i++) begin
            checks++;
            if (i >= got_pc.size() || got_pc[i] !== exp_pc[i] || got_inst[i] !== exp_inst[i] || reqs[i] !== exp_req[i])
                $display("FAIL jal_push%0d: got pc %h addr %h want %h", i, got_pc[i], reqs[i], exp_pc[i]);
            else passes++;
        end
        checks++; if (reqs[5] !== 32'h110) $display("FAIL jal_target: got %h want 00000110", reqs[5]); else passes++;
    endtask

    task automatic test_jalr();
        int n;
        mem_clear();
        for (int i = 0; i < 8; i++) put32(32'(i * 4), rand_addi());
        put32(32'h20, JALR);
        put16(32'h400, CLI);
        put32(32'h402, JALR);
        model_walk(32'h0);
        n = exp_pc.size();
        lat = 1;
        do_reset();
        wait_pushes(n, 400);
        repeat (6) @(negedge clk);
        checks++; if (got_pc.size() != n || reqs.size() != n) $display("FAIL jalr_stall: got %0d pushes %0d reqs want %0d", got_pc.size(), reqs.size(), n); else passes++;
        checks++; if (icache_req !== 1'b0) $display("FAIL jalr_req: got %b want 0", icache_req); else passes++;
        br_rob = 1'b1; rob_target = 32'h400;
        #1;
        checks++; if (iq_push !== 1'b0) $display("FAIL jalr_br_push: got %b want 0", iq_push); else passes++;
        @(negedge clk);
        br_rob = 1'b0;
        model_walk(32'h400);
        wait_pushes(exp_pc.size(), 200);
        checks++; if (clears != 1) $display("FAIL jalr_clear: got %0d pulses want 1", clears); else passes++;
        checks++; if (reqs[n] !== 32'h400) $display("FAIL jalr_redirect: got %h want 00000400", reqs[n]); else passes++;
        checks++; if (got_pc.size() != exp_pc.size()) $display("FAIL jalr_count: got %0d want %0d", got_pc.size(), exp_pc.size()); else passes++;
        for (int i = n; i < exp_pc.size(); i++) begin
            checks++;
            if (i >= got_pc.size() || got_pc[i] !== exp_pc[i] || got_inst[i] !== exp_inst[i] || got_rvc[i] !== exp_rvc[i])
                $display("FAIL jalr_push%0d: got pc %h want %h", i, got_pc[i], exp_pc[i]);
            else passes++;
        end
    endtask

    task automatic test_br_in_wait();
        int b;
        mem_clear();
        put32(32'h0, rand_addi());
        put32(32'h4, JALR);
        put32(32'h400, rand_addi());
        put16(32'h404, CLI);
        put32(32'h406, JALR);
        exp_req.push_back(32'h0);
        model_walk(32'h400);
        lat = 5;
        do_reset();
        b = 50;
        while (reqs.size() < 1 && b > 0) begin @(negedge clk); b--; end
        @(negedge clk);
        br_rob = 1'b1; rob_target = 32'h401;
        @(negedge clk);
        br_rob = 1'b0;
        checks++; if (icache_req !== 1'b0) $display("FAIL wait_drain_req: got %b want 0", icache_req); else passes++;
        wait_pushes(exp_pc.size(), 300);
        checks++; if (clears != 1) $display("FAIL wait_clear: got %0d pulses want 1", clears); else passes++;
        checks++; if (got_pc.size() != exp_pc.size()) $display("FAIL wait_count: got %0d want %0d", got_pc.size(), exp_pc.size()); else passes++;
        checks++; if (reqs.size() != exp_req.size()) $display("FAIL wait_reqs: got %0d want %0d", reqs.size(), exp_req.size()); else passes++;
        for (int i = 0; i < exp_pc.size(); i++) begin
            checks++;
            if (i >= got_pc.size() || got_pc[i] !== exp_pc[i] || got_inst[i] !== exp_inst[i] || reqs[i+1] !== exp_req[i+1])
                $display("FAIL wait_push%0d: got pc %h addr %h want %h", i, got_pc[i], reqs[i+1], exp_pc[i]);
            else passes++;
        end
    endtask

    task automatic test_full_rdy();
        int b;
        logic [31:0] held;
        mem_clear();
        put32(32'h0, rand_addi());
        put32(32'h4, rand_addi());
        put32(32'h8, JALR);
        model_walk(32'h0);
        lat = 1;
        iq_full = 1'b1;
        do_reset();
        b = 50;
        while (inst_ready !== 1'b1 && b > 0) begin @(negedge clk); b--; end
        held = inst_out;
        checks++; if (held !== exp_inst[0]) $display("FAIL full_word: got %h want %h", held, exp_inst[0]); else passes++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (iq_push !== 1'b0 || inst_out !== held || icache_addr !== 32'h0 || inst_ready !== 1'b1)
                $display("FAIL full_hold%0d: got push %b inst %h pc %h want push 0 inst %h pc 0", k, iq_push, inst_out, icache_addr, held);
            else passes++;
        end
        iq_full = 1'b0; rdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (iq_push !== 1'b0 || inst_ready !== 1'b1 || inst_out !== held)
                $display("FAIL rdy_freeze%0d: got push %b ready %b want 0 1", k, iq_push, inst_ready);
            else passes++;
            @(negedge clk);
        end
        checks++; if (got_pc.size() != 0) $display("FAIL freeze_pushes: got %0d want 0", got_pc.size()); else passes++;
        rdy = 1'b1;
        wait_pushes(exp_pc.size(), 200);
        checks++; if (got_pc.size() != exp_pc.size()) $display("FAIL resume_count: got %0d want %0d", got_pc.size(), exp_pc.size()); else passes++;
        for (int i = 0; i < exp_pc.size(); i++) begin
            checks++;
            if (i >= got_pc.size() || got_pc[i] !== exp_pc[i] || got_inst[i] !== exp_inst[i])
                $display("FAIL resume_push%0d: got pc %h inst %h want pc %h inst %h", i, got_pc[i], got_inst[i], exp_pc[i], exp_inst[i]);
            else passes++;
        end
    endtask

    task automatic test_random();
        logic [31:0] p;
        int b;
        for (int r = 0; r < 4; r++) begin
            mem_clear();
            p = 32'h0;
            for (int i = 0; i < 14; i++) begin
                case ($urandom_range(0, 2))
                    0: begin put32(p, rand_addi()); p = p + 4; end
                    1: begin put16(p, {3'b010, 11'($urandom()), 2'b01}); p = p + 2; end
                    default: begin
                        b = 2 * $urandom_range(2, 20);
                        put32(p, enc_jal(21'(b)));
                        p = p + 32'(b);
                    end
                endcase
            end
            put32(p, JALR);
            model_walk(32'h0);
            lat = $urandom_range(1, 4);
            do_reset();
            b = 2000;
            while (got_pc.size() < exp_pc.size() && b > 0) begin
                @(negedge clk);
                iq_full = ($urandom_range(0, 2) == 0);
                b--;
            end
            iq_full = 1'b0;
            repeat (8) @(negedge clk);
            checks++; if (got_pc.size() != exp_pc.size()) $display("FAIL rand%0d_count: got %0d want %0d", r, got_pc.size(), exp_pc.size()); else passes++;
            for (int i = 0; i < exp_pc.size(); i++) begin
                checks++;
                if (i >= got_pc.size() || got_pc[i] !== exp_pc[i] || got_inst[i] !== exp_inst[i] || got_rvc[i] !== exp_rvc[i] || reqs[i] !== exp_req[i])
                    $display("FAIL rand%0d_push%0d: got pc %h inst %h want pc %h inst %h", r, i, got_pc[i], got_inst[i], exp_pc[i], exp_inst[i]);
                else passes++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_rvc();
        test_jal();
        test_jalr();
        test_br_in_wait();
        test_full_rdy();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL timeout: bench did not reach its summary within the time limit");
        $fatal(1);
    end

endmodule
